// File: rtl/spi_ram.sv
// spi_ram: command-decoding byte memory behind an SPI slave.
// Frames on rx_data carry a 2-bit command in [9:8] (write addr, write data,
// read addr, read data) and a payload in [7:0]. Read bytes are presented on
// tx_data/tx_valid; rejected frames pulse err and bump a saturating counter.
module spi_ram #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int AUTO_INC  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic       err,
   output logic [7:0] err_count
);

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_HOLD = 1'b1
   } tx_state_t;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   // Depth held in 9 bits so that 256 is representable next to 8-bit addresses.
   localparam logic [8:0] DEPTH9 = 9'(MEM_DEPTH);

   logic [7:0]           mem [MEM_DEPTH];

   tx_state_t            state;
   logic                 rx_prev;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic                 wr_ok;
   logic                 rd_ok;

   logic                 accept;
   logic [1:0]           cmd;
   logic [ADDR_SIZE-1:0] addr_in;
   logic                 addr_ok;
   logic [8:0]           wr_inc;
   logic [8:0]           rd_inc;
   logic [ADDR_SIZE-1:0] wr_next;
   logic [ADDR_SIZE-1:0] rd_next;
   logic                 do_write;

   // A frame is taken only on the rising edge of rx_valid, so a long valid
   // pulse from the slave still counts as a single frame.
   assign accept  = rx_valid & ~rx_prev;
   assign cmd     = rx_data[9:8];
   assign addr_in = rx_data[ADDR_SIZE-1:0];
   assign addr_ok = (9'(addr_in) < DEPTH9);

   // Post-increment with wrap at MEM_DEPTH (not just at 2^ADDR_SIZE).
   assign wr_inc  = 9'(wr_addr) + 9'd1;
   assign rd_inc  = 9'(rd_addr) + 9'd1;
   assign wr_next = (AUTO_INC == 0) ? wr_addr :
                    (wr_inc == DEPTH9) ? '0 : wr_inc[ADDR_SIZE-1:0];
   assign rd_next = (AUTO_INC == 0) ? rd_addr :
                    (rd_inc == DEPTH9) ? '0 : rd_inc[ADDR_SIZE-1:0];

   assign do_write = rst_n & accept & (cmd == CMD_WR_DATA) & wr_ok;

   // tx_valid is the HOLD state flop itself, so it has no path from rx_*.
   assign tx_valid = (state == TX_HOLD);

   // Memory array: synchronous write, deliberately left untouched by reset.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_addr] <= rx_data[7:0];
      end
   end

   // Command decode, address bookkeeping, tx handshake FSM and error tracking.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= TX_IDLE;
         rx_prev   <= 1'b0;
         tx_data   <= 8'h00;
         err       <= 1'b0;
         err_count <= 8'h00;
         wr_addr   <= '0;
         rd_addr   <= '0;
         wr_ok     <= 1'b0;
         rd_ok     <= 1'b0;
      end else begin
         rx_prev <= rx_valid;
         err     <= 1'b0;
         if (accept) begin
            state <= TX_IDLE;
            case (cmd)
               CMD_WR_ADDR: begin
                  if (addr_ok) begin
                     wr_addr <= addr_in;
                     wr_ok   <= 1'b1;
                  end else begin
                     err <= 1'b1;
                     if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  end
               end
               CMD_WR_DATA: begin
                  if (wr_ok) begin
                     wr_addr <= wr_next;
                  end else begin
                     err <= 1'b1;
                     if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  end
               end
               CMD_RD_ADDR: begin
                  if (addr_ok) begin
                     rd_addr <= addr_in;
                     rd_ok   <= 1'b1;
                  end else begin
                     err <= 1'b1;
                     if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  end
               end
               default: begin
                  if (rd_ok) begin
                     tx_data <= mem[rd_addr];
                     rd_addr <= rd_next;
                     case (state)
                        TX_IDLE: state <= TX_HOLD;
                        default: state <= TX_HOLD;
                     endcase
                  end else begin
                     err <= 1'b1;
                     if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: directed self-checking bench for spi_ram. Instance a uses the
// default 256-entry memory; instance b uses MEM_DEPTH=200 for range checks.
module tb_spi_ram;

   logic       clk;
   logic       rst_n_a;
   logic       rst_n_b;
   logic [9:0] rx_data_a;
   logic       rx_valid_a;
   logic [9:0] rx_data_b;
   logic       rx_valid_b;
   logic [7:0] tx_data_a;
   logic       tx_valid_a;
   logic       err_a;
   logic [7:0] err_count_a;
   logic [7:0] tx_data_b;
   logic       tx_valid_b;
   logic       err_b;
   logic [7:0] err_count_b;

   int checks;
   int failures;

   spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n_a),
      .rx_data   (rx_data_a),
      .rx_valid  (rx_valid_a),
      .tx_data   (tx_data_a),
      .tx_valid  (tx_valid_a),
      .err       (err_a),
      .err_count (err_count_a)
   );

   spi_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8), .AUTO_INC(1)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n_b),
      .rx_data   (rx_data_b),
      .rx_valid  (rx_valid_b),
      .tx_data   (tx_data_b),
      .tx_valid  (tx_valid_b),
      .err       (err_b),
      .err_count (err_count_b)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one frame for 'hold' rising edges, then one low cycle; returns at
   // the falling edge after acceptance so outputs can be sampled directly.
   task automatic applyStimulus(input bit sel_b, input logic [9:0] frame, input int hold);
      @(negedge clk);
      if (sel_b) begin
         rx_data_b  = frame;
         rx_valid_b = 1'b1;
      end else begin
         rx_data_a  = frame;
         rx_valid_a = 1'b1;
      end
      repeat (hold) @(negedge clk);
      rx_valid_a = 1'b0;
      rx_valid_b = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst_n_a    = 1'b0;
      rst_n_b    = 1'b0;
      rx_data_a  = '0;
      rx_valid_a = 1'b0;
      rx_data_b  = '0;
      rx_valid_b = 1'b0;
      repeat (3) @(negedge clk);
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;
      @(negedge clk);

      $display("[TB] reset values");
      checkOutput("rst_tx_valid", 32'(tx_valid_a), 32'd0);
      checkOutput("rst_tx_data", 32'(tx_data_a), 32'h00);
      checkOutput("rst_err", 32'(err_a), 32'd0);
      checkOutput("rst_err_count", 32'(err_count_a), 32'd0);

      $display("[TB] data access with no address loaded");
      applyStimulus(1'b0, 10'h13C, 1);
      checkOutput("noaddr_wr_err", 32'(err_a), 32'd1);
      checkOutput("noaddr_wr_cnt", 32'(err_count_a), 32'd1);
      applyStimulus(1'b0, 10'h300, 1);
      checkOutput("noaddr_rd_err", 32'(err_a), 32'd1);
      checkOutput("noaddr_rd_cnt", 32'(err_count_a), 32'd2);
      checkOutput("noaddr_rd_txv", 32'(tx_valid_a), 32'd0);
      @(negedge clk);
      checkOutput("err_one_cycle", 32'(err_a), 32'd0);

      $display("[TB] basic write/read with held rdata");
      applyStimulus(1'b0, 10'h005, 1);
      checkOutput("waddr_no_err", 32'(err_a), 32'd0);
      applyStimulus(1'b0, 10'h1A5, 1);
      applyStimulus(1'b0, 10'h205, 1);
      @(negedge clk);
      rx_data_a  = 10'h300;
      rx_valid_a = 1'b1;
      @(negedge clk);
      checkOutput("basic_txv", 32'(tx_valid_a), 32'd1);
      checkOutput("basic_txd", 32'(tx_data_a), 32'hA5);
      repeat (4) @(negedge clk);
      checkOutput("held_txv", 32'(tx_valid_a), 32'd1);
      checkOutput("held_txd", 32'(tx_data_a), 32'hA5);
      rx_valid_a = 1'b0;
      applyStimulus(1'b0, 10'h010, 1);
      checkOutput("drop_txv", 32'(tx_valid_a), 32'd0);
      checkOutput("idle_txd_hold", 32'(tx_data_a), 32'hA5);
      checkOutput("basic_cnt", 32'(err_count_a), 32'd2);

      $display("[TB] rx_valid held on wdata");
      applyStimulus(1'b0, 10'h020, 1);
      applyStimulus(1'b0, 10'h177, 20);
      applyStimulus(1'b0, 10'h188, 1);
      applyStimulus(1'b0, 10'h220, 1);
      applyStimulus(1'b0, 10'h300, 1);
      checkOutput("held_wr_first", 32'(tx_data_a), 32'h77);
      applyStimulus(1'b0, 10'h300, 1);
      checkOutput("held_wr_second", 32'(tx_data_a), 32'h88);
      checkOutput("held_wr_txv", 32'(tx_valid_a), 32'd1);

      $display("[TB] auto-increment wrap at 256");
      applyStimulus(1'b0, 10'h0FF, 1);
      applyStimulus(1'b0, 10'h111, 1);
      applyStimulus(1'b0, 10'h122, 1);
      applyStimulus(1'b0, 10'h2FF, 1);
      applyStimulus(1'b0, 10'h300, 1);
      checkOutput("wrap_rd_ff", 32'(tx_data_a), 32'h11);
      applyStimulus(1'b0, 10'h300, 1);
      checkOutput("wrap_rd_00", 32'(tx_data_a), 32'h22);
      applyStimulus(1'b0, 10'h200, 1);
      applyStimulus(1'b0, 10'h300, 1);
      checkOutput("wrap_addr0", 32'(tx_data_a), 32'h22);

      $display("[TB] out of range with MEM_DEPTH=200");
      applyStimulus(1'b1, 10'h0C8, 1);
      checkOutput("oor_waddr_err", 32'(err_b), 32'd1);
      applyStimulus(1'b1, 10'h15A, 1);
      checkOutput("oor_wr_ok_clear", 32'(err_b), 32'd1);
      checkOutput("oor_cnt", 32'(err_count_b), 32'd2);
      applyStimulus(1'b1, 10'h0C7, 1);
      checkOutput("inrange_waddr", 32'(err_b), 32'd0);
      applyStimulus(1'b1, 10'h15A, 1);
      applyStimulus(1'b1, 10'h16B, 1);
      applyStimulus(1'b1, 10'h2C8, 1);
      checkOutput("oor_raddr_err", 32'(err_b), 32'd1);
      applyStimulus(1'b1, 10'h2C7, 1);
      applyStimulus(1'b1, 10'h300, 1);
      checkOutput("b_rd_c7", 32'(tx_data_b), 32'h5A);
      checkOutput("b_rd_c7_txv", 32'(tx_valid_b), 32'd1);
      applyStimulus(1'b1, 10'h300, 1);
      checkOutput("b_rd_wrap0", 32'(tx_data_b), 32'h6B);

      $display("[TB] error counter saturation");
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 10'h0C8, 1);
      end
      checkOutput("sat_cnt", 32'(err_count_b), 32'd255);
      checkOutput("sat_err", 32'(err_b), 32'd1);
      checkOutput("sat_reject_txv", 32'(tx_valid_b), 32'd0);

      $display("[TB] reset while tx_valid is high");
      applyStimulus(1'b0, 10'h205, 1);
      applyStimulus(1'b0, 10'h300, 1);
      checkOutput("pre_rst_txv", 32'(tx_valid_a), 32'd1);
      rst_n_a    = 1'b0;
      rx_data_a  = 10'h205;
      rx_valid_a = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_txv", 32'(tx_valid_a), 32'd0);
      checkOutput("mid_rst_txd", 32'(tx_data_a), 32'h00);
      checkOutput("mid_rst_cnt", 32'(err_count_a), 32'd0);
      rst_n_a = 1'b1;
      @(negedge clk);
      rx_valid_a = 1'b0;
      applyStimulus(1'b0, 10'h300, 1);
      checkOutput("post_rst_accept", 32'(tx_data_a), 32'hA5);
      checkOutput("post_rst_txv", 32'(tx_valid_a), 32'd1);
      applyStimulus(1'b0, 10'h199, 1);
      checkOutput("post_rst_wr_ok", 32'(err_a), 32'd1);
      checkOutput("post_rst_cnt", 32'(err_count_a), 32'd1);
      checkOutput("post_rst_drop", 32'(tx_valid_a), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
